// File: rtl/cpu_control_pkg.sv
// Shared definitions for the cpu_control sequencer.
// Contents: opcode class codes (IR[31:30]), the fixed LOAD/STORE/NOP/HALT
// encodings, the sequencer state enum and the IR field bit positions.
package cpu_control_pkg;

  // Opcode class is the top two opcode bits.
  localparam logic [1:0] ALU_RR = 2'b00;
  localparam logic [1:0] MEM    = 2'b01;
  localparam logic [1:0] CTRL   = 2'b10;
  localparam logic [1:0] ALU_RI = 2'b11;

  localparam logic [5:0] OP_LOAD  = 6'b01_0000;
  localparam logic [5:0] OP_STORE = 6'b01_0001;
  localparam logic [5:0] OP_NOP   = 6'b10_0000;
  localparam logic [5:0] OP_HALT  = 6'b10_1111;

  // IR field positions
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int OPA_MSB = 25;
  localparam int OPA_LSB = 21;
  localparam int OPB_MSB = 20;
  localparam int OPB_LSB = 16;
  localparam int LIT_MSB = 15;
  localparam int LIT_LSB = 0;

  // Fixed encodings so the state register stays legacy-compatible.
  typedef enum logic [2:0] {
    S_BOOT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM_RD = 3'd4,
    S_MEM_WR = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

endpackage

// File: rtl/cpu_instr_decode.sv
// Combinational opcode decoder.
// Ports: opcode (IR[31:26]) in; op_class (opcode class), next_hint (state
// to enter after DECODE), illegal (encoding not in the instruction set) out.
module cpu_instr_decode
  import cpu_control_pkg::*;
(
  input  logic [5:0] opcode,
  output logic [1:0] op_class,
  output state_t     next_hint,
  output logic       illegal
);

  always_comb begin
    op_class  = opcode[5:4];
    next_hint = S_FAULT;
    illegal   = 1'b1;
    case (op_class)
      ALU_RR, ALU_RI: begin
        next_hint = S_EXEC;
        illegal   = 1'b0;
      end
      MEM: begin
        if (opcode == OP_LOAD) begin
          next_hint = S_MEM_RD;
          illegal   = 1'b0;
        end else if (opcode == OP_STORE) begin
          next_hint = S_MEM_WR;
          illegal   = 1'b0;
        end
      end
      default: begin // CTRL
        if (opcode == OP_NOP) begin
          next_hint = S_FETCH;
          illegal   = 1'b0;
        end else if (opcode == OP_HALT) begin
          next_hint = S_HALT;
          illegal   = 1'b0;
        end
      end
    endcase
  end

endmodule

// File: rtl/cpu_control.sv
// Multi-cycle fetch/decode/execute sequencer for the CPU datapath.
// Ports:
//   clk, reset (async, active high)
//   data [WIDTH] / mem_ack          - memory bus and completion strobe
//   mem_rd, mem_wr                  - memory request strobes
//   Valid, regEn, oppA, oppB, opcode, literal, DataCon, AddCon,
//   increment, pc_reset             - datapath controls
//   halted, fault                   - terminal status
// All outputs decode from the state register or the IR; the only path from
// mem_ack to an output is regEn in MEM_RD (captures the load data).
module cpu_control
  import cpu_control_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int AWIDTH  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             mem_ack,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             Valid,
  output logic             regEn,
  output logic [4:0]       oppA,
  output logic [4:0]       oppB,
  output logic [5:0]       opcode,
  output logic [WIDTH-1:0] literal,
  output logic             DataCon,
  output logic             AddCon,
  output logic             increment,
  output logic             pc_reset,
  output logic             halted,
  output logic             fault
);

  // The address bus is driven by the datapath; AWIDTH only documents it.
  localparam int CNT_W = $clog2(TIMEOUT + 1) + (AWIDTH * 0);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] ir;
  logic [CNT_W-1:0] wait_cnt;
  logic             waiting, expired;
  logic [1:0]       op_class;
  state_t           dec_nxt;
  logic             illegal;

  assign opcode  = ir[OPC_MSB:OPC_LSB];
  assign oppA    = ir[OPA_MSB:OPA_LSB];
  assign oppB    = ir[OPB_MSB:OPB_LSB];
  assign literal = {{(WIDTH-16){ir[LIT_MSB]}}, ir[LIT_MSB:LIT_LSB]};

  cpu_instr_decode u_dec (
    .opcode    (opcode),
    .op_class  (op_class),
    .next_hint (dec_nxt),
    .illegal   (illegal)
  );

  // wait_cnt holds the number of ack-less cycles already spent in the
  // current wait state, so the TIMEOUT-th such cycle sees TIMEOUT-1.
  assign waiting = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign expired = waiting && !mem_ack && (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_BOOT:   state_nxt = S_FETCH;
      S_FETCH:  if (mem_ack) state_nxt = S_DECODE;
                else if (expired) state_nxt = S_FAULT;
      S_DECODE: if (illegal) state_nxt = S_FAULT;
                else if (op_class == ALU_RR || op_class == ALU_RI) state_nxt = S_EXEC;
                else state_nxt = dec_nxt;
      S_EXEC:   state_nxt = S_FETCH;
      S_MEM_RD,
      S_MEM_WR: if (mem_ack) state_nxt = S_FETCH;
                else if (expired) state_nxt = S_FAULT;
      default:  state_nxt = state; // HALT / FAULT are terminal
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_BOOT;
      ir       <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && mem_ack) ir <= data;
      if (state_nxt != state)        wait_cnt <= '0;
      else if (waiting && !mem_ack)  wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Moore decode; reset forces BOOT asynchronously so requests drop at once.
  always_comb begin
    pc_reset  = (state == S_BOOT);
    mem_rd    = (state == S_FETCH) || (state == S_MEM_RD);
    mem_wr    = (state == S_MEM_WR);
    Valid     = (state == S_DECODE) || (state == S_EXEC) ||
                (state == S_MEM_RD) || (state == S_MEM_WR);
    increment = (state == S_DECODE);
    regEn     = (state == S_EXEC) || ((state == S_MEM_RD) && mem_ack);
    DataCon   = (state == S_EXEC) || (state == S_MEM_WR);
    AddCon    = (state == S_MEM_RD) || (state == S_MEM_WR);
    halted    = (state == S_HALT);
    fault     = (state == S_FAULT);
  end

endmodule

// File: doc/cpu_control.md
Name: cpu_control

Overview:
- Multi-cycle fetch/decode/execute sequencer for the CPU datapath.
- Drives every datapath control input: register-file enable and selects, ALU opcode, literal, data/address bus steering, PC increment and PC reset.
- Performs the memory read/write handshake and holds the instruction register.
- Sits between the datapath and the memory.

Parameters:
WIDTH, 32, data/instruction word width
AWIDTH, 8, address bus width (informational; the controller never drives the address)
TIMEOUT, 15, maximum wait cycles for mem_ack before fault

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
data  in  WIDTH  shared data bus, sampled on fetch/load ack
mem_ack  in  1  memory completion strobe
mem_rd  out  1  memory read request
mem_wr  out  1  memory write request
Valid  out  1  decoded fields stable
regEn  out  1  register-file write enable
oppA  out  5  register select A / destination
oppB  out  5  register select B
opcode  out  6  datapath opcode
literal  out  WIDTH  sign-extended immediate
DataCon  out  1  datapath drives data bus
AddCon  out  1  address bus = ALU result (0 = PC)
increment  out  1  PC increment pulse
pc_reset  out  1  PC reset
halted  out  1  HALT executed
fault  out  1  illegal opcode or memory timeout

Behaviour:
- Instruction format in the IR: opcode=IR[31:26], oppA=IR[25:21], oppB=IR[20:16], literal=sign-extend(IR[15:0]). These outputs come from the IR; IR resets to 0.
- Opcode classes:
  - 00xxxx: ALU reg-reg.
  - 11xxxx: ALU reg-literal.
  - 01_0000: LOAD, address = oppA + literal.
  - 01_0001: STORE.
  - 10_0000: NOP.
  - 10_1111: HALT.
  - All other encodings are illegal.
- States: BOOT, FETCH, DECODE, EXEC, MEM_RD, MEM_WR, HALT, FAULT.
- While reset is high:
  - state=BOOT, pc_reset=1.
  - All other outputs are 0; timeout counter is 0.
- BOOT: pc_reset=1 for exactly one clock after reset deassertion, then FETCH.
- FETCH:
  - mem_rd=1, AddCon=0, DataCon=0.
  - On mem_ack: latch data into the IR and go to DECODE.
- DECODE:
  - Valid=1, increment=1 for this single cycle.
  - Next state:
    - ALU classes -> EXEC.
    - LOAD -> MEM_RD.
    - STORE -> MEM_WR.
    - NOP -> FETCH.
    - HALT -> HALT.
    - Illegal -> FAULT.
- EXEC: Valid=1, DataCon=1, AddCon=0, regEn=1 for one cycle, then FETCH.
- MEM_RD:
  - Valid=1, AddCon=1, mem_rd=1.
  - In the mem_ack cycle: regEn=1 (captures data), then FETCH.
- MEM_WR:
  - Valid=1, AddCon=1, DataCon=1, mem_wr=1 held until mem_ack, then FETCH.
  - regEn=0 throughout.
- Timeout counter:
  - Counts cycles spent in FETCH, MEM_RD or MEM_WR without mem_ack.
  - Clears on state entry.
  - When it reaches TIMEOUT with no ack -> FAULT. mem_ack in the TIMEOUT-th cycle counts as success.
- HALT: halted=1, all strobes 0; terminal until reset.
- FAULT: fault=1, all strobes 0; terminal until reset.
- Outputs are registered or decoded from state only; never combinational from mem_ack. Exception: regEn in MEM_RD is gated by mem_ack.
- mem_rd and mem_wr are never both 1. regEn and mem_wr are never both 1.
- mem_ack outside FETCH/MEM_RD/MEM_WR is ignored.
- Reset asserted mid-access: immediate return to BOOT; requests drop asynchronously.
- Instruction latency:
  - ALU: 3 cycles plus fetch wait.
  - LOAD/STORE: 3 cycles plus fetch wait plus memory wait.

Decomposition:
- Shared package holds:
  - opcode class constants (ALU_RR, MEM, CTRL, ALU_RI);
  - LOAD/STORE/NOP/HALT encodings;
  - state enum;
  - IR field bit positions.
- One sub-module, cpu_instr_decode: purely combinational IR -> class, next-state hint, illegal flag.

Test Plan:
- Reset, release, ack fetch of 0x00A2_0003 with ack delay 0 -> pc_reset for 1 cycle; DECODE shows opcode=0, oppA=5, oppB=2, literal=3; increment pulses once; EXEC regEn=1, DataCon=1, AddCon=0.
- Fetch LOAD with literal 0xFFFC, ack delay 2 -> literal=0xFFFF_FFFC; MEM_RD holds AddCon=1 and mem_rd=1 for 3 cycles; regEn=1 only in the ack cycle.
- Fetch STORE -> mem_wr=1, AddCon=1, DataCon=1 until ack; regEn stays 0; next fetch has AddCon=0.
- Withhold mem_ack for 15 cycles in FETCH -> fault=1, all strobes 0. Ack in cycle 15 instead -> normal DECODE.
- Fetch 0xBC00_0000 (HALT) -> halted=1, no further mem_rd. Fetch opcode 10_0101 -> fault=1.
- Assert reset mid-MEM_WR -> mem_wr drops in the same cycle, pc_reset=1, BOOT on release.
